// File: rtl/pb_event_gen_pkg.sv
// Shared definitions for the push-button event generator: FSM state
// encodings, the default prescaler length and small elaboration helpers.
package pb_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HELD    = 2'd3
    } pb_state_t;

    // 50 MHz board clock -> 1 ms tick
    localparam int CLK_PER_MS_DEF = 50000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a counter running 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pb_event_gen_if.sv
// Button level in, event pulses / held level / press count out.
// master: the event generator; slave: whoever supplies the level and
// consumes the events.
interface pb_event_gen_if #(
    parameter int CNT_W = 8
);
    logic             pb_level;
    logic             press_p;
    logic             release_p;
    logic             long_p;
    logic             repeat_p;
    logic             held;
    logic [CNT_W-1:0] press_cnt;

    modport master (
        input  pb_level,
        output press_p,
        output release_p,
        output long_p,
        output repeat_p,
        output held,
        output press_cnt
    );

    modport slave (
        output pb_level,
        input  press_p,
        input  release_p,
        input  long_p,
        input  repeat_p,
        input  held,
        input  press_cnt
    );
endinterface

// File: rtl/pb_ms_tick.sv
// Free-running millisecond prescaler: counts 0..CLK_PER_MS-1 and raises
// tick for the single cycle in which the count sits at its terminal value.
module pb_ms_tick
    import pb_event_gen_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int           W  = cnt_width(CLK_PER_MS);
    localparam logic [W-1:0] TC = W'(CLK_PER_MS - 1);

    logic [W-1:0] count;

    // Wrapping prescaler count, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == TC) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == TC);

endmodule

// File: rtl/pb_event_gen.sv
// Push-button event generator: turns the debounced button level into
// one-cycle press / release / long-press / auto-repeat pulses, a held level
// and a wrapping press counter.
// Optional feature macro: PB_AUTOREPEAT_EN (periodic repeat_p while held).
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ARM     | after reset; wait for a settled, released button
//  IDLE    | released; waiting for a press
//  PRESSED | pressed, counting ms ticks towards the long-press time
//  HELD    | long press reached; waiting for release (and repeating)
module pb_event_gen
    import pb_event_gen_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    parameter int CNT_W      = 8
) (
    input logic           clk,
    input logic           rst_n,
    pb_event_gen_if.master bus
);

    localparam int              MS_W    = $clog2(max2(LONG_MS, REPEAT_MS) + 1);
    localparam logic [MS_W-1:0] LONG_TC = MS_W'(LONG_MS - 1);
`ifdef PB_AUTOREPEAT_EN
    localparam logic [MS_W-1:0] REP_TC  = MS_W'(REPEAT_MS - 1);
`endif

    logic             sync_q;
    logic             pb_s;
    logic [1:0]       sync_fill;
    logic             tick;

    pb_state_t        state;
    pb_state_t        state_nxt;
    logic [MS_W-1:0]  ms_cnt;
    logic [MS_W-1:0]  ms_cnt_nxt;
    logic [CNT_W-1:0] press_cnt_q;
    logic [CNT_W-1:0] press_cnt_nxt;
    logic             press_q;
    logic             press_nxt;
    logic             release_q;
    logic             release_nxt;
    logic             long_q;
    logic             long_nxt;
    logic             held_q;
    logic             held_nxt;
`ifdef PB_AUTOREPEAT_EN
    logic             repeat_q;
    logic             repeat_nxt;
`endif

    pb_ms_tick #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_ms_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Two-flop synchroniser; sync_fill marks when pb_s holds a real sample
    // again, so ARM never acts on the cleared reset value of the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= 1'b0;
            pb_s      <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            sync_q    <= bus.pb_level;
            pb_s      <= sync_q;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_ARM;
            ms_cnt      <= '0;
            press_cnt_q <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            held_q      <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
            repeat_q    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            ms_cnt      <= ms_cnt_nxt;
            press_cnt_q <= press_cnt_nxt;
            press_q     <= press_nxt;
            release_q   <= release_nxt;
            long_q      <= long_nxt;
            held_q      <= held_nxt;
`ifdef PB_AUTOREPEAT_EN
            repeat_q    <= repeat_nxt;
`endif
        end
    end

    // Next-state and next-output decode; release is tested before the tick
    // so it always wins over a coincident long or repeat.
    always_comb begin
        state_nxt     = state;
        ms_cnt_nxt    = ms_cnt;
        press_cnt_nxt = press_cnt_q;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
`ifdef PB_AUTOREPEAT_EN
        repeat_nxt    = 1'b0;
`endif
        case (state)
            ST_ARM: begin
                if (sync_fill[1] && !pb_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (pb_s) begin
                    state_nxt     = ST_PRESSED;
                    press_nxt     = 1'b1;
                    press_cnt_nxt = press_cnt_q + 1'b1;
                    ms_cnt_nxt    = '0;
                end
            end
            ST_PRESSED: begin
                if (!pb_s) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    if (ms_cnt == LONG_TC) begin
                        state_nxt  = ST_HELD;
                        long_nxt   = 1'b1;
                        ms_cnt_nxt = '0;
                    end else begin
                        ms_cnt_nxt = ms_cnt + 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (!pb_s) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                end
`ifdef PB_AUTOREPEAT_EN
                else if (tick) begin
                    if (ms_cnt == REP_TC) begin
                        repeat_nxt = 1'b1;
                        ms_cnt_nxt = '0;
                    end else begin
                        ms_cnt_nxt = ms_cnt + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_nxt = ST_ARM;
            end
        endcase
        held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_HELD);
    end

    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.long_p    = long_q;
    assign bus.held      = held_q;
    assign bus.press_cnt = press_cnt_q;
`ifdef PB_AUTOREPEAT_EN
    assign bus.repeat_p  = repeat_q;
`else
    assign bus.repeat_p  = 1'b0;
`endif

endmodule

// File: tb/tb_pb_event_gen.sv
// Directed bench for pb_event_gen with an event scoreboard: each stimulus
// step queues the events it should cause, and a negedge monitor pops and
// compares them (kind, press count, timing) as the DUT emits pulses.
module tb_pb_event_gen;

    localparam int CLK_PER_MS = 4;
    localparam int LONG_MS    = 5;
    localparam int REPEAT_MS  = 2;
    localparam int CNT_W      = 8;
    localparam int LAT        = 3;
    localparam int LONG_LO    = (LONG_MS - 1) * CLK_PER_MS + 1;
    localparam int LONG_HI    = LONG_MS * CLK_PER_MS;
    localparam int REP_GAP    = REPEAT_MS * CLK_PER_MS;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t       sb_q[$];
    int         cyc           = 0;
    int         rst_last      = 0;
    int         last_press_cyc = 0;
    int         last_lr_cyc   = 0;
    int         n_asserts     = 0;
    int         n_fail        = 0;
    logic [7:0] exp_cnt       = 8'd0;

    pb_event_gen_if #(.CNT_W(CNT_W)) bus ();

    pb_event_gen #(
        .CLK_PER_MS(CLK_PER_MS),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push(input ev_t k, input int c);
        exp_t e;
        e.kind = k;
        e.cnt  = exp_cnt;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic drive_press(output int p_cyc);
        bus.pb_level = 1'b1;
        exp_cnt++;
        p_cyc = cyc + LAT;
        push(EV_PRESS, p_cyc);
    endtask

    task automatic drive_release();
        bus.pb_level = 1'b0;
        push(EV_RELEASE, cyc + LAT);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        steps(n);
        rst_n    = 1'b1;
        rst_last = cyc;
        exp_cnt  = 8'd0;
    endtask

    // Scoreboard monitor: any pulse must match the head of the queue.
    always @(negedge clk) begin
        logic [3:0] ev;
        exp_t       e;
        ev_t        obs_k;
        ev = {bus.repeat_p, bus.long_p, bus.release_p, bus.press_p};
        if (ev != 4'b0000) begin
            check("one_hot", 32'($onehot(ev)), 32'd1);
            n_asserts++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_event: observed pulses %b at cycle %0d, expected none", ev, cyc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                obs_k = ev[0] ? EV_PRESS : ev[1] ? EV_RELEASE : ev[2] ? EV_LONG : EV_REPEAT;
                check("event_kind", obs_k, e.kind);
                check("event_press_cnt", 32'(bus.press_cnt), 32'(e.cnt));
                case (e.kind)
                    EV_PRESS, EV_RELEASE: check("event_latency", cyc, e.cyc);
                    EV_LONG: begin
                        n_asserts++;
                        assert ((cyc - last_press_cyc >= LONG_LO) && (cyc - last_press_cyc <= LONG_HI)) else begin
                            n_fail++;
                            $error("FAIL long_delay: observed %0d cycles after press, expected %0d..%0d",
                                   cyc - last_press_cyc, LONG_LO, LONG_HI);
                        end
                    end
                    default: check("repeat_gap", cyc - last_lr_cyc, REP_GAP);
                endcase
                if (obs_k == EV_PRESS) last_press_cyc = cyc;
                if (obs_k == EV_LONG || obs_k == EV_REPEAT) last_lr_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        int t1;
        int x;
        rst_n        = 1'b0;
        bus.pb_level = 1'b0;

        // Reset state
        do_reset(3);
        check("rst_press_p", bus.press_p, 0);
        check("rst_release_p", bus.release_p, 0);
        check("rst_long_p", bus.long_p, 0);
        check("rst_repeat_p", bus.repeat_p, 0);
        check("rst_held", bus.held, 0);
        check("rst_press_cnt", bus.press_cnt, 0);
        steps(5);

        // 1: short press (3 ticks)
        drive_press(p);
        steps(5);
        check("t1_held_on", bus.held, 1);
        check("t1_cnt", bus.press_cnt, 1);
        steps(7);
        drive_release();
        steps(6);
        check("t1_drain", sb_q.size(), 0);
        check("t1_held_off", bus.held, 0);

        // 2: long hold, release lands between first and second repeat
        drive_press(p);
        push(EV_LONG, -1);
`ifdef PB_AUTOREPEAT_EN
        push(EV_REPEAT, -1);
`endif
        steps(31);
        check("t2_held_on", bus.held, 1);
        drive_release();
        steps(6);
        check("t2_drain", sb_q.size(), 0);
        check("t2_cnt", bus.press_cnt, 2);
        check("t2_repeat_idle", bus.repeat_p, 0);

        // 3: button held through reset emits nothing
        bus.pb_level = 1'b1;
        do_reset(3);
        steps(12);
        check("t3_cnt_held_rst", bus.press_cnt, 0);
        check("t3_held_armed", bus.held, 0);
        bus.pb_level = 1'b0;
        steps(6);
        drive_press(p);
        steps(6);
        check("t3_held_on", bus.held, 1);
        check("t3_cnt", bus.press_cnt, 1);
        drive_release();
        steps(6);
        check("t3_drain", sb_q.size(), 0);

        // 4: counter wrap after 256 presses, then one more
        do_reset(2);
        steps(5);
        for (int i = 0; i < 256; i++) begin
            drive_press(p);
            steps(5);
            drive_release();
            steps(5);
        end
        check("t4_wrap", bus.press_cnt, 0);
        drive_press(p);
        steps(5);
        check("t4_after_wrap", bus.press_cnt, 1);
        drive_release();
        steps(6);
        check("t4_drain", sb_q.size(), 0);

        // 5: release coincides with the long-press tick
        drive_press(p);
        t1 = p + 1;
        while (((t1 - rst_last) % CLK_PER_MS) != 0) t1++;
        x = t1 + (LONG_MS - 1) * CLK_PER_MS;
        steps(x - LAT - cyc);
        drive_release();
        steps(30);
        check("t5_drain", sb_q.size(), 0);
        check("t5_held_off", bus.held, 0);

        // 6: reset while HELD
        drive_press(p);
        push(EV_LONG, -1);
        steps(p + LONG_HI + 1 - cyc);
        check("t6_held_before", bus.held, 1);
        check("t6_drain_before", sb_q.size(), 0);
        rst_n = 1'b0;
        step();
        check("t6_rst_press_p", bus.press_p, 0);
        check("t6_rst_release_p", bus.release_p, 0);
        check("t6_rst_long_p", bus.long_p, 0);
        check("t6_rst_repeat_p", bus.repeat_p, 0);
        check("t6_rst_held", bus.held, 0);
        check("t6_rst_cnt", bus.press_cnt, 0);
        steps(2);
        rst_n    = 1'b1;
        rst_last = cyc;
        exp_cnt  = 8'd0;
        steps(10);
        check("t6_armed_held", bus.held, 0);
        bus.pb_level = 1'b0;
        steps(10);
        check("t6_no_release", sb_q.size(), 0);
        drive_press(p);
        steps(5);
        check("t6_rearm_cnt", bus.press_cnt, 1);
        drive_release();
        steps(6);
        check("t6_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
